// File: rtl/video_console_pkg.sv
// Shared definitions for the text console write sequencer:
// opcodes, ASCII constants, nibble-to-hex-digit conversion and FSM encoding.
// No ports; imported by video_console_cursor and video_console_ctrl.
package video_console_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUTC   = 3'd1;
    localparam logic [2:0] OP_NL     = 3'd2;
    localparam logic [2:0] OP_HOME   = 3'd3;
    localparam logic [2:0] OP_SETPOS = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;
    localparam logic [2:0] OP_HEX    = 3'd6;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_HEX  = 2'd2
    } state_t;

    // 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (0x37 + 10 = 'A')
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/video_console_cursor.sv
// Text cursor: column, row and linear RAM address (row*TW+col) kept in step.
// Ports: clk/rst/clk_en; one-cycle strobes adv, nl, home, setpos (+ set_col/set_row);
// outputs col, row, adr. Address is updated incrementally; only setpos multiplies (by constant TW).
module video_console_cursor
    import video_console_pkg::*;
#(
    parameter int TW  = 80,
    parameter int TH  = 2,
    parameter int MAW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           adv,
    input  logic           nl,
    input  logic           home,
    input  logic           setpos,
    input  logic [7:0]     set_col,
    input  logic [7:0]     set_row,
    output logic [7:0]     col,
    output logic [7:0]     row,
    output logic [MAW-1:0] adr
);

    localparam logic [7:0]     COL_MAX = 8'(TW - 1);
    localparam logic [7:0]     ROW_MAX = 8'(TH - 1);
    localparam logic [MAW-1:0] ROW_LEN = MAW'(TW);

    logic [7:0] col_cl;
    logic [7:0] row_cl;

    assign col_cl = (set_col > COL_MAX) ? COL_MAX : set_col;
    assign row_cl = (set_row > ROW_MAX) ? ROW_MAX : set_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            adr <= '0;
        end else if (clk_en) begin
            if (home) begin
                col <= '0;
                row <= '0;
                adr <= '0;
            end else if (setpos) begin
                col <= col_cl;
                row <= row_cl;
                adr <= MAW'(row_cl) * ROW_LEN + MAW'(col_cl);
            end else if (nl) begin
                col <= '0;
                if (row == ROW_MAX) begin
                    row <= '0;
                    adr <= '0;
                end else begin
                    row <= row + 8'd1;
                    // back to start of this row, then one row down
                    adr <= adr - MAW'(col) + ROW_LEN;
                end
            end else if (adv) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    if (row == ROW_MAX) begin
                        row <= '0;
                        adr <= '0;
                    end else begin
                        row <= row + 8'd1;
                        // last column of row r + 1 is first column of row r+1
                        adr <= adr + 1'b1;
                    end
                end else begin
                    col <= col + 8'd1;
                    adr <= adr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/video_console_ctrl.sv
// Command-driven write sequencer for the console character RAM write port.
// Ports: clk/rst/clk_en; cmd_valid/cmd_ready/cmd_op/cmd_dat command handshake;
// cur_col/cur_row cursor; busy; registered RAM write port con_we/con_adr_w/con_dat_w.
module video_console_ctrl
    import video_console_pkg::*;
#(
    parameter int TW  = 80,
    parameter int TH  = 2,
    parameter int MAW = 8,
    parameter int MDW = 8,
    parameter int HW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [HW-1:0]  cmd_dat,
    output logic [7:0]     cur_col,
    output logic [7:0]     cur_row,
    output logic           busy,
    output logic           con_we,
    output logic [MAW-1:0] con_adr_w,
    output logic [MDW-1:0] con_dat_w
);

    localparam int             NNIB     = HW / 4;
    localparam int             NBW      = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [MAW-1:0] CLR_LAST = MAW'(TW * TH - 1);

    state_t         state, state_nxt;
    logic [MAW-1:0] clr_cnt, clr_nxt;
    logic [NBW-1:0] nib_cnt, nib_nxt;
    logic [HW-1:0]  hex_dat, hex_nxt;

    logic           wr;
    logic [MAW-1:0] wr_adr;
    logic [MDW-1:0] wr_dat;
    logic           c_adv, c_nl, c_home, c_set;
    logic           accept;
    logic [MAW-1:0] cur_adr;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready && clk_en;

    video_console_cursor #(
        .TW  (TW),
        .TH  (TH),
        .MAW (MAW)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .adv     (c_adv),
        .nl      (c_nl),
        .home    (c_home),
        .setpos  (c_set),
        .set_col (cmd_dat[7:0]),
        .set_row (cmd_dat[15:8]),
        .col     (cur_col),
        .row     (cur_row),
        .adr     (cur_adr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        wr_adr    = cur_adr;
        wr_dat    = '0;
        c_adv     = 1'b0;
        c_nl      = 1'b0;
        c_home    = 1'b0;
        c_set     = 1'b0;
        clr_nxt   = clr_cnt;
        nib_nxt   = nib_cnt;
        hex_nxt   = hex_dat;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_PUTC: begin
                            wr     = 1'b1;
                            wr_dat = MDW'(cmd_dat[7:0]);
                            c_adv  = 1'b1;
                        end
                        OP_NL:     c_nl   = 1'b1;
                        OP_HOME:   c_home = 1'b1;
                        OP_SETPOS: c_set  = 1'b1;
                        OP_CLEAR: begin
                            // address 0 is written on the accept edge itself
                            wr        = 1'b1;
                            wr_adr    = '0;
                            wr_dat    = MDW'(ASCII_SPACE);
                            clr_nxt   = MAW'(1);
                            state_nxt = S_CLR;
                        end
                        OP_HEX: begin
                            // most significant digit goes out on the accept edge
                            wr        = 1'b1;
                            wr_dat    = MDW'(nib2ascii(cmd_dat[HW-1 -: 4]));
                            c_adv     = 1'b1;
                            hex_nxt   = cmd_dat;
                            nib_nxt   = NBW'(NNIB - 2);
                            state_nxt = S_HEX;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLR: begin
                wr     = 1'b1;
                wr_adr = clr_cnt;
                wr_dat = MDW'(ASCII_SPACE);
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = S_IDLE;
                    c_home    = 1'b1;
                end else begin
                    clr_nxt = clr_cnt + 1'b1;
                end
            end
            S_HEX: begin
                wr     = 1'b1;
                wr_dat = MDW'(nib2ascii(hex_dat[{nib_cnt, 2'b00} +: 4]));
                c_adv  = 1'b1;
                if (nib_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    nib_nxt = nib_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt   <= '0;
            nib_cnt   <= '0;
            hex_dat   <= '0;
            con_we    <= 1'b0;
            con_adr_w <= '0;
            con_dat_w <= '0;
        end else if (clk_en) begin
            clr_cnt <= clr_nxt;
            nib_cnt <= nib_nxt;
            hex_dat <= hex_nxt;
            con_we  <= wr;
            if (wr) begin
                con_adr_w <= wr_adr;
                con_dat_w <= wr_dat;
            end
        end
    end

endmodule

// File: tb/tb_video_console_ctrl.sv
// Bench for video_console_ctrl: directed commands push expected RAM writes into a queue,
// an independent monitor pops and compares every write seen in an enabled cycle.
// Ports: none (top-level bench).
module tb_video_console_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_dat;
    logic [7:0]  cur_col;
    logic [7:0]  cur_row;
    logic        busy;
    logic        con_we;
    logic [7:0]  con_adr_w;
    logic [7:0]  con_dat_w;

    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] dat;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    logic tog = 1'b0;

    video_console_ctrl #(
        .TW (80), .TH (2), .MAW (8), .MDW (8), .HW (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dat   (cmd_dat),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy),
        .con_we    (con_we),
        .con_adr_w (con_adr_w),
        .con_dat_w (con_dat_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a write counts once per enabled cycle in which con_we is high.
    always @(negedge clk) begin
        if (!rst && con_we && clk_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual adr=%0d dat=%0h expected none", con_adr_w, con_dat_w);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_adr", {24'h0, con_adr_w}, {24'h0, e.adr});
                chk("wr_dat", {24'h0, con_dat_w}, {24'h0, e.dat});
            end
        end
    end

    // Optional clk_en toggling, changes just after the active edge.
    always @(posedge clk) begin
        #1;
        if (tog) clk_en = ~clk_en;
    end

    function automatic logic [7:0] hexch(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        return tbl[n];
    endfunction

    task automatic push(input int adr, input logic [7:0] dat);
        wr_t e;
        e.adr = adr[7:0];
        e.dat = dat;
        sb.push_back(e);
    endtask

    // Issue a command; returns #1 after the accepting edge. waits = enabled cycles spent not ready.
    task automatic send(input logic [2:0] op, input logic [31:0] d, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        cmd_op    = op;
        cmd_dat   = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready && clk_en) begin
                acc = 1'b1;
                break;
            end
            if (!cmd_ready && clk_en) waits++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted op=%0d", op);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic chk_cur(input string name, input int c, input int r);
        chk({name, "_col"}, {24'h0, cur_col}, c);
        chk({name, "_row"}, {24'h0, cur_row}, r);
    endtask

    initial begin
        int w;
        logic [31:0] hv;
        rst       = 1'b1;
        clk_en    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dat   = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        chk("rst_ready", {31'h0, cmd_ready}, 1);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_we", {31'h0, con_we}, 0);
        chk("rst_adr", {24'h0, con_adr_w}, 0);
        chk("rst_dat", {24'h0, con_dat_w}, 0);
        chk_cur("rst", 0, 0);

        // PUTC 'A' : visible the cycle after accept, gone the cycle after that
        push(0, 8'h41);
        send(3'd1, 32'h41, w);
        chk("putc_we", {31'h0, con_we}, 1);
        chk("putc_adr", {24'h0, con_adr_w}, 0);
        chk("putc_dat", {24'h0, con_dat_w}, 32'h41);
        chk_cur("putc", 1, 0);
        @(posedge clk);
        #1;
        chk("putc_we_clear", {31'h0, con_we}, 0);

        // end of row 0, end of screen wrap, clamping
        send(3'd4, {16'h0, 8'd0, 8'd79}, w);
        chk_cur("setpos79_0", 79, 0);
        push(79, 8'h78);
        send(3'd1, 32'h78, w);
        chk_cur("wrap_row", 0, 1);
        send(3'd4, {16'h0, 8'd1, 8'd79}, w);
        push(159, 8'h79);
        send(3'd1, 32'h79, w);
        chk_cur("wrap_screen", 0, 0);
        send(3'd4, {16'h0, 8'd9, 8'd200}, w);
        chk_cur("setpos_clamp", 79, 1);

        // NL / HOME / NOP / opcode 7
        send(3'd2, 32'h0, w);
        chk_cur("nl_wrap", 0, 0);
        send(3'd2, 32'h0, w);
        chk_cur("nl", 0, 1);
        send(3'd4, {16'h0, 8'd1, 8'd5}, w);
        send(3'd2, 32'h0, w);
        chk_cur("nl_mid", 0, 0);
        send(3'd4, {16'h0, 8'd1, 8'd5}, w);
        send(3'd0, 32'h0, w);
        send(3'd7, 32'h41, w);
        chk_cur("nop", 5, 1);
        send(3'd3, 32'h0, w);
        chk_cur("home", 0, 0);

        // CLEAR with a PUTC queued behind it
        for (int i = 0; i < 160; i++) push(i, 8'h20);
        push(0, 8'h51);
        send(3'd5, 32'h0, w);
        chk("clr_busy", {31'h0, busy}, 1);
        send(3'd1, 32'h51, w);
        chk("clr_ready_low", w, 159);
        chk_cur("after_clr", 1, 0);

        // back-to-back PUTC
        push(1, 8'h61);
        push(2, 8'h62);
        send(3'd1, 32'h61, w);
        send(3'd1, 32'h62, w);
        chk("b2b_we", {31'h0, con_we}, 1);
        chk_cur("b2b", 3, 0);

        // HEX at (10,1)
        send(3'd4, {16'h0, 8'd1, 8'd10}, w);
        hv = 32'h12AB_CDEF;
        for (int i = 0; i < 8; i++) push(90 + i, hexch(hv[28 - 4*i +: 4]));
        send(3'd6, hv, w);
        send(3'd0, 32'h0, w);
        chk("hex_busy_cycles", w, 7);
        chk_cur("hex", 18, 1);

        // HEX with clk_en toggling 1010...
        send(3'd3, 32'h0, w);
        hv = 32'h9F05_E3C7;
        for (int i = 0; i < 8; i++) push(i, hexch(hv[28 - 4*i +: 4]));
        tog = 1'b1;
        send(3'd6, hv, w);
        send(3'd0, 32'h0, w);
        chk("hexen_busy_cycles", w, 7);
        tog    = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cur("hexen", 8, 0);

        // reset on the 50th CLEAR write
        for (int i = 0; i < 50; i++) push(i, 8'h20);
        send(3'd5, 32'h0, w);
        repeat (49) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_we", {31'h0, con_we}, 0);
        chk("abort_ready", {31'h0, cmd_ready}, 1);
        chk("abort_busy", {31'h0, busy}, 0);
        chk_cur("abort", 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_we_after", {31'h0, con_we}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
